fifo_level: RTL
===============

Name: fifo_level

Overview:
Parametrised synchronous FIFO with valid/grant handshakes on both sides and first-word fall-through output. Supports any depth ≥ 2, including non-power-of-two depths. Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. Sits between stream producers and consumers in the datapath.

Parameters:
DATA_WIDTH, 32, payload width in bits (data is [DATA_WIDTH-1:0])
FIFO_DEPTH, 8, number of entries; any integer ≥ 2
AF_LEVEL, FIFO_DEPTH-1, almost_full_o asserted when count ≥ AF_LEVEL
AE_LEVEL, 1, almost_empty_o asserted when count ≤ AE_LEVEL

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous clear of the FIFO contents
push_data_i  input  DATA_WIDTH  write payload
push_valid_i  input  1  producer offers push_data_i
push_grant_o  output  1  FIFO can accept a write this cycle
pop_grant_i  input  1  consumer accepts pop_data_o
pop_data_o  output  DATA_WIDTH  head entry (fall-through)
pop_valid_o  output  1  pop_data_o holds valid data
count_o  output  CW  occupancy, CW = $clog2(FIFO_DEPTH+1)
almost_full_o  output  1  count_o ≥ AF_LEVEL
almost_empty_o  output  1  count_o ≤ AE_LEVEL
overflow_o  output  1  sticky: push_valid_i was high while push_grant_o was low
underflow_o  output  1  sticky: pop_grant_i was high while pop_valid_o was low

Behaviour:
- Reset (asynchronous, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, overflow_o=0, underflow_o=0. Resulting outputs: push_grant_o=1, pop_valid_o=0, almost_empty_o=1, almost_full_o=0 (for AF_LEVEL ≥ 1). Storage contents are not reset. The same values apply when rst_n asserts mid-transfer.
- Derived signals:
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - push_grant_o = !full; pop_valid_o = !empty.
  - push_req = push_valid_i && push_grant_o; pop_req = pop_grant_i && pop_valid_o.
- Push: on push_req, write mem[wr_ptr]. wr_ptr wraps from FIFO_DEPTH-1 to 0, with no power-of-two assumption.
- Pop: pop_data_o = mem[rd_ptr], combinational. On pop_req, rd_ptr wraps from FIFO_DEPTH-1 to 0.
- Latency: a push into an empty FIFO sets pop_valid_o on the next cycle. There is no same-cycle bypass.
- Count update per cycle:
  - +1 on push only; -1 on pop only; unchanged when both occur.
  - count_o, almost_full_o and almost_empty_o are combinational from the count register.
- Simultaneous events:
  - Full, with pop_grant_i=1 and push_valid_i=1: the pop is taken, the push is refused (grant=0), and overflow_o is set.
  - Empty, with both requests: the push is taken; the pop is refused and underflow_o is set.
  - Neither full nor empty: both are taken and count is unchanged.
- Flush (flush_i=1): pointers and count return to 0 on the next edge. Flush has priority over push/pop in the same cycle, so data pushed in that cycle is discarded. Flush also clears overflow_o and underflow_o; the error sets from that cycle are not applied.
- Error flags: overflow_o and underflow_o are set one cycle after the offending cycle. They remain set until reset or flush.
- Invariants:
  - count_o ≤ FIFO_DEPTH.
  - (wr_ptr - rd_ptr) mod FIFO_DEPTH == count mod FIFO_DEPTH.
- Elaboration: AF_LEVEL must lie in 1..FIFO_DEPTH and AE_LEVEL in 0..FIFO_DEPTH-1. An elaboration-time assertion enforces both ranges.

Decomposition:
- Package fifo_pkg holds:
  - function cnt_width(depth), returning $clog2(depth+1);
  - function ptr_width(depth), returning max(1, $clog2(depth));
  - localparam defaults for DATA_WIDTH and FIFO_DEPTH.
- Sub-module fifo_storage (FIFO_DEPTH x DATA_WIDTH register array):
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr → rdata);
  - no reset.
- Pointer, count and flag logic stay in fifo_level.

Test Plan:
1. Reset, then push 0x11..0x88 with pop_grant_i=0 (DEPTH=8) → after 8 pushes, count_o=8, push_grant_o=0, almost_full_o=1 from count 7 onward; a 9th push_valid_i sets overflow_o=1 the next cycle.
2. From full, pop 8 times at pop_grant_i=1 → output order 0x11..0x88; after the last pop, pop_valid_o=0 and count_o=0; a further pop_grant_i sets underflow_o=1.
3. DEPTH=5 with simultaneous push/pop every cycle for 23 cycles after pre-filling 2 entries → count_o holds at 2, data order is preserved across several pointer wraps, and no error flag sets.
4. Push into an empty FIFO with pop_grant_i=1 held → pop_valid_o=0 in the push cycle and 1 in the next cycle with pop_data_o=pushed value; underflow_o=1 because of the empty-cycle grant.
5. Fill to 3, then assert flush_i together with push_valid_i=1 (data 0xAA) → next cycle count_o=0, pop_valid_o=0, error flags 0, and 0xAA is never output.
6. Drop rst_n asynchronously mid-stream at count 4 → count_o=0, pop_valid_o=0 and push_grant_o=1 immediately without a clock edge; normal operation resumes after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameters for the fifo_level FIFO.
// Width functions let non-power-of-two depths size pointers and counters correctly.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_storage.sv
// FIFO_DEPTH x DATA_WIDTH register array with a synchronous write port and
// an asynchronous read port; contents are intentionally left unreset.
module fifo_storage #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_level.sv
// First-word fall-through FIFO with occupancy count, almost-full/empty flags,
// synchronous flush and sticky overflow/underflow error flags.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_valid_i,
  output logic                  push_grant_o,
  input  logic                  pop_grant_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  pop_valid_o,
  output logic [CW-1:0]         count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PW = ptr_width(FIFO_DEPTH);

  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH || AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1)
  begin : gen_levelCheck
    $error("fifo_level: AF_LEVEL must be in 1..FIFO_DEPTH and AE_LEVEL in 0..FIFO_DEPTH-1");
  end

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          full, empty, pushReq, popReq;

  // Explicit wrap so depths that are not a power of two never index past the array.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pushReq = push_valid_i & ~full;
  assign popReq  = pop_grant_i & ~empty;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush_i) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (pushReq) wrPtr_d = nextPtr(wrPtr_q);
      if (popReq)  rdPtr_d = nextPtr(rdPtr_q);
      if (pushReq && !popReq) begin
        count_d = count_q + CW'(1);
      end else if (popReq && !pushReq) begin
        count_d = count_q - CW'(1);
      end
      overflow_d  = overflow_q | (push_valid_i & full);
      underflow_d = underflow_q | (pop_grant_i & empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (PW)
  ) u_storage (
    .clk     (clk),
    .we_i    (pushReq & ~flush_i),
    .waddr_i (wrPtr_q),
    .wdata_i (push_data_i),
    .raddr_i (rdPtr_q),
    .rdata_o (pop_data_o)
  );

  assign push_grant_o   = ~full;
  assign pop_valid_o    = ~empty;
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty_o = (count_q <= CW'(AE_LEVEL));
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
